// File: rtl/mem_read_master_ysyx23060136_if.sv
// Load request/response and peripheral read-bus signals between the core
// MEM stage, the read master, and the memory-mapped responders.
interface mem_read_master_ysyx23060136_if;
    // Core-side load request and response
    logic        load_req_valid;
    logic        load_req_ready;
    logic [31:0] load_addr;
    logic [2:0]  load_size;
    logic        load_unsigned;
    logic        load_resp_valid;
    logic [63:0] load_resp_data;
    logic        load_resp_err;

    // Peripheral read bus
    logic [31:0] MEM_raddr;
    logic [2:0]  MEM_rsize;
    logic        MEM_raddr_valid;
    logic        MEM_raddr_ready;
    logic [63:0] MEM_rdata;
    logic        MEM_rdata_valid;
    logic        MEM_rdata_ready;

    // The read master's view
    modport master (
        input  load_req_valid, load_addr, load_size, load_unsigned,
        output load_req_ready, load_resp_valid, load_resp_data, load_resp_err,
        output MEM_raddr, MEM_rsize, MEM_raddr_valid, MEM_rdata_ready,
        input  MEM_raddr_ready, MEM_rdata, MEM_rdata_valid
    );

    // The environment's view: core on one side, responder on the other
    modport slave (
        output load_req_valid, load_addr, load_size, load_unsigned,
        input  load_req_ready, load_resp_valid, load_resp_data, load_resp_err,
        input  MEM_raddr, MEM_rsize, MEM_raddr_valid, MEM_rdata_ready,
        output MEM_raddr_ready, MEM_rdata, MEM_rdata_valid
    );
endinterface

// File: rtl/mem_read_master_ysyx23060136.sv
// Read-channel initiator: turns one core load into one read transaction on
// the peripheral bus, extracts and extends the addressed lane of the
// returned doubleword, and reports misalignment, illegal size or an
// unresponsive slave as an error response instead of stalling the core.
module mem_read_master_ysyx23060136 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    mem_read_master_ysyx23060136_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_MAX = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   data_q, data_d;
    logic          err_q, err_d;

    // A request is legal when its size is 0..3 and the address is naturally
    // aligned to that size.
    function automatic logic request_ok(input logic [2:0] offs, input logic [2:0] size);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (offs[0] == 1'b0);
            3'd2:    ok = (offs[1:0] == 2'b00);
            3'd3:    ok = (offs == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Shift the addressed byte lane down to bit 0 and extend it to 64 bits.
    // Dword reads are always returned as-is, whatever load_unsigned says.
    function automatic logic [63:0] extract(input logic [63:0] rdata,
                                            input logic [2:0]  offs,
                                            input logic [2:0]  size,
                                            input logic        uns);
        logic [63:0] lane;
        logic [63:0] ext;
        lane = rdata >> {offs, 3'b000};
        case (size)
            3'd0:    ext = uns ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            3'd1:    ext = uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            3'd2:    ext = uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: ext = lane;
        endcase
        return ext;
    endfunction

    // Next-state and datapath decision for the four-phase transaction.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.load_req_valid) begin
                    addr_d     = bus.load_addr;
                    size_d     = bus.load_size;
                    unsigned_d = bus.load_unsigned;
                    if (request_ok(bus.load_addr[2:0], bus.load_size)) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                    end else begin
                        // Rejected without touching the bus.
                        state_d = S_RESP;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                // A handshake coinciding with expiry still proceeds.
                if (bus.MEM_raddr_ready) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_MAX) begin
                    state_d = S_RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bus.MEM_rdata_valid) begin
                    state_d = S_RESP;
                    data_d  = extract(bus.MEM_rdata, addr_q[2:0], size_q, unsigned_q);
                    err_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_MAX) begin
                    state_d = S_RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                // Response is a single-cycle pulse with no back-pressure.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here is small control/datapath state, so all
        // of them take the reset value; the bus outputs depend on it.
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Handshake outputs are decoded from state only, never from responder inputs.
    assign bus.load_req_ready  = (state_q == S_IDLE);
    assign bus.load_resp_valid = (state_q == S_RESP);
    assign bus.load_resp_data  = data_q;
    assign bus.load_resp_err   = err_q;
    assign bus.MEM_raddr       = addr_q;
    assign bus.MEM_rsize       = size_q;
    assign bus.MEM_raddr_valid = (state_q == S_ADDR);
    assign bus.MEM_rdata_ready = (state_q == S_DATA);

endmodule

// File: tb/tb_mem_read_master_ysyx23060136.sv
// Bench for the read master: directed cases plus randomized loads with a
// randomized responder, checked against an arithmetic reference model.
module tb_mem_read_master_ysyx23060136;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mem_read_master_ysyx23060136_if bus ();

    mem_read_master_ysyx23060136 #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: legality from natural alignment, value from byte arithmetic.
    function automatic void ref_load(input logic [31:0] addr, input logic [2:0] size,
                                     input logic uns, input logic [63:0] rdata,
                                     output logic legal, output logic [63:0] val);
        int unsigned nbytes;
        int unsigned offs;
        int unsigned bits;
        logic [63:0] mask;
        if (size > 3'd3) begin
            legal = 1'b0;
            val   = '0;
            return;
        end
        nbytes = 32'd1 << size;
        legal  = (addr % nbytes) == 0;
        if (!legal) begin
            val = '0;
            return;
        end
        offs = addr % 8;
        val  = rdata >> (8 * offs);
        if (nbytes < 8) begin
            bits = 8 * nbytes;
            mask = (64'd1 << bits) - 64'd1;
            val  = val & mask;
            if (!uns && val[bits-1]) val = val | ~mask;
        end
    endfunction

    // One complete load; ar_dly/dv_dly are the responder stall cycles in each
    // phase (above T means the responder never answers in that phase).
    task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                            input logic u, input logic [63:0] rd,
                            input int ar_dly, input int dv_dly,
                            output logic [63:0] got_data);
        logic legal;
        logic [63:0] exp_data;
        logic exp_err;
        int exp_cyc;
        int n_ar = 0;
        int n_dv = 0;
        int first_av = -1;
        int resp_cyc = -1;
        int bad_stab = 0;
        logic got_err = 1'b0;
        got_data = 'x;

        ref_load(a, sz, u, rd, legal, exp_data);
        exp_err = !legal;
        if (!legal) exp_cyc = 1;
        else if (ar_dly > T) begin exp_cyc = T + 2; exp_err = 1'b1; exp_data = '0; end
        else if (dv_dly > T) begin exp_cyc = ar_dly + T + 3; exp_err = 1'b1; exp_data = '0; end
        else exp_cyc = ar_dly + dv_dly + 3;

        @(negedge clk);
        check({tag, ".req_ready"}, 64'(bus.load_req_ready), 64'd1);
        bus.load_req_valid = 1'b1;
        bus.load_addr      = a;
        bus.load_size      = sz;
        bus.load_unsigned  = u;

        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.load_req_valid = 1'b0;
            bus.load_addr      = $urandom;
            if (bus.MEM_raddr_valid) begin
                n_ar++;
                if (first_av < 0) first_av = cyc;
            end
            if (bus.MEM_raddr_valid || bus.MEM_rdata_ready)
                if (bus.MEM_raddr !== a || bus.MEM_rsize !== sz) bad_stab++;
            bus.MEM_raddr_ready = bus.MEM_raddr_valid && (n_ar > ar_dly);
            if (bus.MEM_rdata_ready) n_dv++;
            bus.MEM_rdata_valid = bus.MEM_rdata_ready && (n_dv > dv_dly);
            bus.MEM_rdata       = bus.MEM_rdata_valid ? rd : ~rd;
            if (bus.load_resp_valid) begin
                resp_cyc = cyc;
                got_data = bus.load_resp_data;
                got_err  = bus.load_resp_err;
                break;
            end
        end
        bus.MEM_raddr_ready = 1'b0;
        bus.MEM_rdata_valid = 1'b0;

        check({tag, ".resp_cycle"}, 64'(resp_cyc), 64'(exp_cyc));
        check({tag, ".data"}, got_data, exp_data);
        check({tag, ".err"}, 64'(got_err), 64'(exp_err));
        check({tag, ".first_addr_valid"}, 64'(first_av), legal ? 64'd1 : 64'(-1));
        check({tag, ".addr_stable"}, 64'(bad_stab), 64'd0);
        @(negedge clk);
        check({tag, ".pulse_one_cycle"}, 64'(bus.load_resp_valid), 64'd0);
        check({tag, ".ready_again"}, 64'(bus.load_req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        logic [31:0] ra;
        logic [2:0]  rs;
        int          ad;
        int          dd;
        int          saw_resp;

        bus.load_req_valid  = 1'b0;
        bus.load_addr       = '0;
        bus.load_size       = '0;
        bus.load_unsigned   = 1'b0;
        bus.MEM_raddr_ready = 1'b0;
        bus.MEM_rdata       = '0;
        bus.MEM_rdata_valid = 1'b0;

        #1 rst = 1'b1;
        @(negedge clk);
        check("reset.req_ready", 64'(bus.load_req_ready), 64'd1);
        check("reset.resp_valid", 64'(bus.load_resp_valid), 64'd0);
        check("reset.resp_err", 64'(bus.load_resp_err), 64'd0);
        check("reset.resp_data", bus.load_resp_data, 64'd0);
        check("reset.raddr_valid", 64'(bus.MEM_raddr_valid), 64'd0);
        check("reset.rdata_ready", 64'(bus.MEM_rdata_ready), 64'd0);
        check("reset.raddr", 64'(bus.MEM_raddr), 64'd0);
        check("reset.rsize", 64'(bus.MEM_rsize), 64'd0);
        rst = 1'b0;

        // Directed cases
        run_load("mtime", 32'h0200_BFF8, 3'd3, 1'b0, 64'h0000_0001_2345_6789, 0, 0, d);
        check("mtime.value", d, 64'h0000_0001_2345_6789);
        run_load("byte_s", 32'h8000_0005, 3'd0, 1'b0, 64'h0000_F300_0000_0000, 0, 0, d);
        check("byte_s.value", d, 64'hFFFF_FFFF_FFFF_FFF3);
        run_load("byte_u", 32'h8000_0005, 3'd0, 1'b1, 64'h0000_F300_0000_0000, 0, 0, d);
        check("byte_u.value", d, 64'h0000_0000_0000_00F3);
        run_load("word_misaligned", 32'h8000_0002, 3'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, d);
        run_load("size5", 32'h8000_0008, 3'd5, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, d);
        run_load("addr_timeout", 32'h1000_0000, 3'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, 100, 0, d);
        run_load("delayed", 32'h8000_0004, 3'd2, 1'b0, 64'h8765_4321_0000_0000, 3, 2, d);
        run_load("ar_at_expiry", 32'h8000_0006, 3'd1, 1'b1, 64'hABCD_0000_0000_0000, T, 0, d);
        run_load("dv_at_expiry", 32'h8000_0003, 3'd0, 1'b0, 64'h0000_0000_8000_0000, 0, T, d);
        run_load("data_timeout", 32'h8000_0010, 3'd3, 1'b0, 64'h0102_0304_0506_0708, 1, T + 1, d);

        // Asynchronous reset while in DATA, after a result left data nonzero
        run_load("pre_reset", 32'h0200_BFF8, 3'd3, 1'b0, 64'h0000_0001_2345_6789, 0, 0, d);
        @(negedge clk);
        bus.load_req_valid = 1'b1;
        bus.load_addr      = 32'h8000_0018;
        bus.load_size      = 3'd3;
        bus.load_unsigned  = 1'b0;
        @(negedge clk);
        bus.load_req_valid  = 1'b0;
        bus.MEM_raddr_ready = bus.MEM_raddr_valid;
        @(negedge clk);
        bus.MEM_raddr_ready = 1'b0;
        check("rst_mid.in_data", 64'(bus.MEM_rdata_ready), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.req_ready", 64'(bus.load_req_ready), 64'd1);
        check("rst_mid.resp_valid", 64'(bus.load_resp_valid), 64'd0);
        check("rst_mid.resp_err", 64'(bus.load_resp_err), 64'd0);
        check("rst_mid.resp_data", bus.load_resp_data, 64'd0);
        check("rst_mid.raddr_valid", 64'(bus.MEM_raddr_valid), 64'd0);
        check("rst_mid.rdata_ready", 64'(bus.MEM_rdata_ready), 64'd0);
        check("rst_mid.raddr", 64'(bus.MEM_raddr), 64'd0);
        check("rst_mid.rsize", 64'(bus.MEM_rsize), 64'd0);
        saw_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.load_resp_valid) saw_resp++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.load_resp_valid) saw_resp++;
        end
        check("rst_mid.no_resp_pulse", 64'(saw_resp), 64'd0);
        run_load("after_reset", 32'h8000_0022, 3'd1, 1'b0, 64'h0000_0000_9ABC_0000, 1, 1, d);

        // Randomized loads against the reference model
        for (int n = 0; n < 40; n++) begin
            rs = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            ra = $urandom;
            if (rs < 3'd4 && $urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
            ad = ($urandom_range(0, 9) == 0) ? T + 1 : int'($urandom_range(0, T));
            dd = ($urandom_range(0, 9) == 0) ? T + 1 : int'($urandom_range(0, T));
            run_load($sformatf("rand%0d", n), ra, rs, 1'($urandom_range(0, 1)),
                     {$urandom, $urandom}, ad, dd, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_read_master_ysyx23060136.md
# mem_read_master_ysyx23060136

Read-channel initiator that turns a single core load request into one transaction on the easy AXI-lite read protocol used by the memory-mapped peripherals, including the CLINT mtime port. It sits between the MEM stage and the peripheral read bus. It drives address/size, collects the returned 64-bit doubleword, and extracts the addressed lane with sign or zero extension. It reports misalignment and unresponsive slaves as errors instead of hanging the core.

## Interface
- TIMEOUT_CYCLES, 255, cycles without a handshake in ADDR or DATA before the transaction aborts with error; ≥1
- clk  in  1  core clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- load_req_valid  in  1  core presents a load
- load_req_ready  out  1  block can accept a load (high only in IDLE)
- load_addr  in  32  byte address
- load_size  in  3  0=byte, 1=half, 2=word, 3=dword; 4–7 illegal
- load_unsigned  in  1  1=zero-extend, 0=sign-extend
- load_resp_valid  out  1  one-cycle pulse: result available
- load_resp_data  out  64  extended load result; 0 on error
- load_resp_err  out  1  qualified by load_resp_valid: misaligned, illegal size, or timeout
- MEM_raddr  out  32  read address (latched load_addr, unmodified)
- MEM_rsize  out  3  latched load_size
- MEM_raddr_valid  out  1  address phase active
- MEM_raddr_ready  in  1  responder accepts address
- MEM_rdata  in  64  naturally aligned doubleword containing MEM_raddr
- MEM_rdata_valid  in  1  responder data valid
- MEM_rdata_ready  out  1  block accepts data

## Operation
- States: IDLE, ADDR, DATA, RESP. Reset → IDLE.
- IDLE: load_req_ready=1. On load_req_valid, latch addr/size/unsigned.
  - If the request is legal and aligned → ADDR.
  - If the size is illegal or the address is misaligned → RESP with err=1 and data=0. No bus transaction is issued.
  - Alignment: half needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0.
- ADDR: MEM_raddr_valid=1, with MEM_raddr/MEM_rsize stable from the latches. When MEM_raddr_ready is sampled high → DATA.
- DATA: MEM_rdata_ready=1. When MEM_rdata_valid is sampled high, register the extracted result → RESP.
- RESP: load_resp_valid=1 for exactly one cycle → IDLE. The response is not back-pressured.
- Extraction: lane = MEM_rdata >> (8*addr[2:0]).
  - Byte uses lane[7:0], half uses lane[15:0], word uses lane[31:0], dword uses the full 64 bits.
  - Bits above the lane are filled with zero if unsigned, otherwise with the lane MSB.
  - Dword ignores load_unsigned.
- Timeout: the counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ADDR and on entry to DATA. It increments every cycle spent in ADDR or DATA without the phase handshake.
  - When it reaches TIMEOUT_CYCLES, the block goes to RESP with err=1 and data=0. MEM_raddr_valid and MEM_rdata_ready drop in that same transition.
  - The handshake wins if it coincides with expiry.
- Unmapped addresses that a responder never acknowledges must therefore terminate with an error.
- Async reset at any point: return immediately to IDLE and clear all outputs. An in-flight transaction is abandoned with no response pulse.

## Timing
- Reset values:
  - load_req_ready=1 (IDLE).
  - load_resp_valid=0, load_resp_err=0, load_resp_data=0.
  - MEM_raddr_valid=0, MEM_rdata_ready=0, MEM_raddr=0, MEM_rsize=0.
- MEM_raddr_valid and MEM_rdata_ready are decoded from state only. They have no combinational path from responder inputs.
- Best-case latency, with a responder that acks address immediately and ties rdata_valid to rdata_ready:
  - Request accepted at cycle 0.
  - ADDR at cycle 1.
  - DATA at cycle 2.
  - load_resp_valid at cycle 3.
- Error latency for misaligned or illegal requests: load_resp_valid one cycle after acceptance.
- Timeout in ADDR: load_resp_valid in cycle 1+TIMEOUT_CYCLES+1 after acceptance.
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE). The minimum issue interval is 4 cycles.
- load_resp_data/err hold their value until the next RESP; they are only meaningful while valid is high.

## Test plan
- Dword read at the mtime address (aligned, size 3), with the responder returning 64'h0000_0001_2345_6789 and acking immediately. Required: MEM_raddr_valid high in cycle 1, resp in cycle 3 with data 64'h0000_0001_2345_6789 and err=0.
- Byte read at addr ending 0x5, with MEM_rdata=64'h0000_F300_0000_0000. Required: signed gives 64'hFFFF_FFFF_FFFF_FFF3; unsigned gives 64'h0000_0000_0000_00F3.
- Word read at addr ending 0x2, and size=5 at an aligned addr. Required for both: resp err=1 and data=0 one cycle after acceptance, with MEM_raddr_valid never asserted.
- Responder never asserts MEM_raddr_ready, with TIMEOUT_CYCLES=4. Required: err=1 in cycle 6 after acceptance, then load_req_ready=1 again.
- MEM_raddr_ready delayed 3 cycles and MEM_rdata_valid delayed 2 cycles. Required: address and size stay stable throughout, and the correct resp arrives at cycle 8.
- Reset asserted asynchronously while in DATA. Required: all outputs return to reset values without waiting for a clock edge, no resp pulse, and a fresh request afterwards completes normally.
